// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART TX FIFO write port
// Optional per-grant header byte state is enabled by defining UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_afull,
  output logic [7:0]           fifo_data,
  output logic                 fifo_wr,
  output logic [2:0]           grant_id,
  output logic                 busy
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_XFER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] rr_q, rr_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] idle_q, idle_d;
  logic [7:0] data_q, data_d;
  logic       wr_q, wr_d;
  logic       release_c;

  // Requester vectors widened to the 3-bit grant index space.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);

  logic [3:0] cand;
  logic [2:0] pick;

  // Descending scan so the lowest offset from rr_q is the last to win.
  always_comb begin
    pick = rr_q;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (valid_pad[cand[2:0]]) pick = cand[2:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    idle_d    = idle_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    release_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          burst_d = '0;
          idle_d  = '0;
`ifdef UART_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_XFER;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        if (!fifo_afull) begin
          data_d  = 8'hF0 | {5'd0, grant_q};
          wr_d    = 1'b1;
          state_d = S_XFER;
        end
      end
`endif
      S_XFER: begin
        if (valid_pad[grant_q]) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 8'd1;
          if (idle_d == 8'(IDLE_TIMEOUT)) release_c = 1'b1;
        end
        if (valid_pad[grant_q] && !fifo_afull) begin
          data_d  = data_pad[{grant_q, 3'b000} +: 8];
          wr_d    = 1'b1;
          burst_d = burst_q + 8'd1;
          if (last_pad[grant_q] || burst_d == 8'(MAX_BURST)) release_c = 1'b1;
        end
        if (release_c) begin
          state_d = S_IDLE;
          rr_d    = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_XFER) && (grant_q == 3'(i)) && !fifo_afull;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign grant_id  = busy ? grant_q : 3'd0;
  assign fifo_data = data_q;
  assign fifo_wr   = wr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized self-checking bench for uart_tx_arbiter
// Honours UART_ARB_TAG_EN to expect the per-grant header byte.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 8;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_afull;
  logic [7:0]           fifo_data;
  logic                 fifo_wr;
  logic [2:0]           grant_id;
  logic                 busy;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_afull(fifo_afull),
    .fifo_data(fifo_data),
    .fifo_wr(fifo_wr),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-requester byte queues: bit 8 is the last flag.
  logic [8:0] mem [NUM_REQ][256];
  int hd [NUM_REQ];
  int tl [NUM_REQ];
  logic [NUM_REQ-1:0] gate;
  logic afull_drv;
  bit   rand_mode;

  // Reference model: 0 idle, 1 transfer, 2 header.
  int m_state, m_g, m_cnt, m_idle, m_rr;
  bit exp_wr;
  logic [7:0] exp_data;

  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int r, logic [7:0] d, bit last);
    mem[r][tl[r]] = {last, d};
    tl[r]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < NUM_REQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic exp_hdr(int g);
    if (TAG_EN) exp_q.push_back(8'hF0 | 8'(g));
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (hd[i] < tl[i]) p = 1'b1;
    return p;
  endfunction

  task automatic cycle();
    logic [NUM_REQ-1:0] v;
    logic [7:0] nd;
    bit nwr, rel, acc, lst;
    int pk;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (hd[i] < tl[i]) && gate[i];
      req_data[8*i +: 8] = mem[i][hd[i]][7:0];
      req_last[i] = mem[i][hd[i]][8];
    end
    req_valid  = v;
    fifo_afull = afull_drv;
    #1;
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("grant_id", 32'(grant_id), (m_state != 0) ? 32'(m_g) : 32'd0);
    chk("req_ready", 32'(req_ready), (m_state == 1 && !afull_drv) ? 32'(1 << m_g) : 32'd0);
    chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
    if (exp_wr) chk("fifo_data", 32'(fifo_data), 32'(exp_data));
    if (fifo_wr === 1'b1) log_q.push_back(fifo_data);

    nwr = 1'b0;
    nd  = 8'h00;
    rel = 1'b0;
    lst = 1'b0;
    acc = (m_state == 1) && v[m_g] && !afull_drv;
    if (acc) begin
      nd  = mem[m_g][hd[m_g]][7:0];
      lst = mem[m_g][hd[m_g]][8];
      hd[m_g]++;
    end
    if (!reset_n) begin
      m_state = 0;
      m_g     = 0;
      m_rr    = 0;
    end else begin
      case (m_state)
        0: begin
          if (v != '0) begin
            pk = -1;
            for (int k = 0; k < NUM_REQ; k++)
              if (pk < 0 && v[(m_rr + k) % NUM_REQ]) pk = (m_rr + k) % NUM_REQ;
            m_g     = pk;
            m_cnt   = 0;
            m_idle  = 0;
            m_state = TAG_EN ? 2 : 1;
          end
        end
        2: begin
          if (!afull_drv) begin
            nwr     = 1'b1;
            nd      = 8'hF0 | 8'(m_g);
            m_state = 1;
          end
        end
        default: begin
          if (v[m_g]) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == IDLE_TIMEOUT) rel = 1'b1;
          end
          if (acc) begin
            nwr = 1'b1;
            m_cnt++;
            if (lst || m_cnt == MAX_BURST) rel = 1'b1;
          end
          if (rel) begin
            m_state = 0;
            m_rr    = (m_g + 1) % NUM_REQ;
          end
        end
      endcase
    end
    exp_wr   = nwr;
    exp_data = nd;
    if (rand_mode) begin
      gate      = NUM_REQ'($urandom | $urandom);
      afull_drv = ($urandom_range(0, 4) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(string tag);
    int n = 0;
    while ((pending() || m_state != 0 || exp_wr) && n < 3000) begin
      cycle();
      n++;
    end
    chk({tag, "_done"}, 32'(n < 3000), 32'd1);
    cycle();
  endtask

  task automatic log_check(string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n    = 1'b0;
    gate       = '1;
    afull_drv  = 1'b0;
    rand_mode  = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    fifo_afull = 1'b0;
    clear_q();
    m_state = 0; m_g = 0; m_cnt = 0; m_idle = 0; m_rr = 0;
    exp_wr = 1'b0; exp_data = 8'h00;

    // Reset held with every requester asserting valid.
    for (int r = 0; r < NUM_REQ; r++) push(r, 8'h10 + 8'(r), 1'b1);
    @(posedge clk);
    #1;
    repeat (10) begin
      cycle();
      chk("rst_fifo_data", 32'(fifo_data), 32'h00);
    end
    reset_n = 1'b1;
    log_q.delete();
    cycle();
    chk("first_grant_busy", 32'(busy), 32'd1);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    run_idle("t1");
    for (int r = 0; r < NUM_REQ; r++) begin
      exp_hdr(r);
      exp_q.push_back(8'h10 + 8'(r));
    end
    log_check("t1_stream");

    // Two short bursts from requesters 0 and 2.
    clear_q();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    run_idle("t2");
    exp_hdr(0); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_hdr(2); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    log_check("t2_stream");

    // Burst limit: requester 1 streams 20 bytes, requester 3 waits.
    clear_q();
    for (int k = 0; k < 20; k++) push(1, 8'h40 + 8'(k), 1'b0);
    cycle();
    push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b0); push(3, 8'hC3, 1'b1);
    run_idle("t3");
    exp_hdr(1);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h40 + 8'(k));
    exp_hdr(3); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    exp_hdr(1);
    for (int k = 16; k < 20; k++) exp_q.push_back(8'h40 + 8'(k));
    log_check("t3_stream");

    // Almost-full stall mid-burst.
    clear_q();
    for (int k = 0; k < 10; k++) push(0, 8'h60 + 8'(k), k == 9);
    repeat (4) cycle();
    afull_drv = 1'b1;
    repeat (5) begin
      cycle();
      chk("afull_ready", 32'(req_ready), 32'd0);
    end
    afull_drv = 1'b0;
    run_idle("t4");
    exp_hdr(0);
    for (int k = 0; k < 10; k++) exp_q.push_back(8'h60 + 8'(k));
    log_check("t4_stream");

    // Inactivity timeout hands over to the next pending requester.
    clear_q();
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0);
    push(3, 8'h7F, 1'b1);
    run_idle("t5");
    exp_hdr(2); exp_q.push_back(8'h70); exp_q.push_back(8'h71);
    exp_hdr(3); exp_q.push_back(8'h7F);
    log_check("t5_stream");

`ifdef UART_ARB_TAG_EN
    clear_q();
    push(2, 8'h5A, 1'b1);
    run_idle("t6");
    exp_q.push_back(8'hF2); exp_q.push_back(8'h5A);
    log_check("t6_stream");
`endif

    // Reset in the middle of a burst.
    clear_q();
    for (int k = 0; k < 10; k++) push(0, 8'h80 + 8'(k), k == 9);
    repeat (4) cycle();
    reset_n = 1'b0;
    cycle();
    chk("rst_mid_wr", 32'(fifo_wr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    hd[0] = tl[0];
    run_idle("t7");
    log_q.delete();
    exp_q.delete();

    // Randomized traffic with random gating and almost-full.
    clear_q();
    for (int r = 0; r < NUM_REQ; r++)
      for (int k = 0; k < 40; k++) push(r, 8'($urandom), $urandom_range(0, 5) == 0);
    rand_mode = 1'b1;
    repeat (1500) cycle();
    rand_mode = 1'b0;
    gate      = '1;
    afull_drv = 1'b0;
    run_idle("rand");
    chk("rand_drained", 32'(pending()), 32'd0);
    log_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
